// File: rtl/lane_bit_mapper_pkg.sv
// Shared mode encodings for the lane bit mapper and its per-lane permutation.
package map_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_FWD    = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_REV    = 2'b11;

  typedef logic [1:0] map_mode_t;

endpackage

// File: rtl/lane_bit_mapper_perm.sv
// Combinational per-lane bit permutation: bypass, interleave, de-interleave, reversal.
module lane_bit_perm
  import map_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] din_i,
  input  map_mode_t         mode_i,
  output logic [LANE_W-1:0] dout_o
);

  localparam int H = LANE_W / 2;

  logic [LANE_W-1:0] fwd, inv, rev;

  // FWD gathers odd bits (MSB first) into the low half, even bits into the high half.
  always_comb begin
    fwd = '0;
    inv = '0;
    rev = '0;
    for (int k = 0; k < H; k++) begin
      fwd[k]              = din_i[LANE_W-1-2*k];
      fwd[H+k]            = din_i[LANE_W-2-2*k];
      inv[LANE_W-1-2*k]   = din_i[k];
      inv[LANE_W-2-2*k]   = din_i[H+k];
    end
    for (int j = 0; j < LANE_W; j++) begin
      rev[j] = din_i[LANE_W-1-j];
    end
  end

  always_comb begin
    case (mode_i)
      MODE_FWD: dout_o = fwd;
      MODE_INV: dout_o = inv;
      MODE_REV: dout_o = rev;
      default:  dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/lane_bit_mapper.sv
// Registered lane bit mapper with valid/ready and a one-entry skid buffer.
// Define MAP_PARITY_EN to register per-lane even parity on out_par; otherwise it is tied to 0.
module lane_bit_mapper
  import map_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8,
  localparam int DW       = NUM_LANES * LANE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [NUM_LANES-1:0] out_par
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_in, lane_out;
  logic [DW-1:0]                    perm_data;

  assign lane_in   = in_data;
  assign perm_data = lane_out;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_bit_perm #(.LANE_W(LANE_W)) u_perm (
      .din_i  (lane_in[g]),
      .mode_i (map_mode_t'(in_mode)),
      .dout_o (lane_out[g])
    );
  end

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic          skid_full_q, skid_full_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          accept, out_free, out_load, skid_load;

  // in_ready comes straight from the skid flop; rst only forces it low while held.
  assign in_ready  = !skid_full_q && !rst;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign out_load  = out_free && (skid_full_q || accept);
  assign skid_load = !out_free && accept;

  // A full skid implies in_ready=0, so skid and input never compete for the output.
  always_comb begin
    out_valid_d = out_free ? (skid_full_q || accept) : out_valid_q;
    out_data_d  = out_data_q;
    if (out_load) out_data_d = skid_full_q ? skid_data_q : perm_data;
    skid_full_d = skid_load ? 1'b1 : (out_free ? 1'b0 : skid_full_q);
    skid_data_d = skid_load ? perm_data : skid_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef MAP_PARITY_EN
  logic [NUM_LANES-1:0] perm_par;
  logic [NUM_LANES-1:0] out_par_q, out_par_d;
  logic [NUM_LANES-1:0] skid_par_q, skid_par_d;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) perm_par[i] = ^lane_out[i];
  end

  always_comb begin
    out_par_d = out_par_q;
    if (out_load) out_par_d = skid_full_q ? skid_par_q : perm_par;
    skid_par_d = skid_load ? perm_par : skid_par_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_par_q  <= '0;
      skid_par_q <= '0;
    end else begin
      out_par_q  <= out_par_d;
      skid_par_q <= skid_par_d;
    end
  end

  assign out_par = out_par_q;
`else
  assign out_par = '0;
`endif

endmodule

// File: tb/tb_lane_bit_mapper.sv
// Directed bench for lane_bit_mapper: modes, parity, skid backpressure, reset, parameter sweep.
module tb_lane_bit_mapper;
  import map_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 4 lanes x 8 bits
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [1:0]  a_in_mode = '0;
  logic [3:0]  a_out_par;
  // 2 lanes x 16 bits
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_in_data = '0, b_out_data;
  logic [1:0]  b_in_mode = '0;
  logic [1:0]  b_out_par;
  // 1 lane x 2 bits
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
  logic [1:0]  c_in_data = '0, c_out_data;
  logic [1:0]  c_in_mode = '0;
  logic [0:0]  c_out_par;

  lane_bit_mapper #(.NUM_LANES(4), .LANE_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_par(a_out_par));

  lane_bit_mapper #(.NUM_LANES(2), .LANE_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_par(b_out_par));

  lane_bit_mapper #(.NUM_LANES(1), .LANE_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_mode(c_in_mode), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_par(c_out_par));

  task automatic txn_a(input logic [1:0] m, input logic [31:0] d,
                       output logic v, output logic [31:0] q, output logic [3:0] p);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_mode = m; a_in_data = d; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    v = a_out_valid; q = a_out_data; p = a_out_par;
  endtask

  task automatic txn_b(input logic [1:0] m, input logic [31:0] d,
                       output logic v, output logic [31:0] q);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_mode = m; b_in_data = d; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    v = b_out_valid; q = b_out_data;
  endtask

  task automatic txn_c(input logic [1:0] m, input logic [1:0] d,
                       output logic v, output logic [1:0] q);
    @(negedge clk);
    c_in_valid = 1'b1; c_in_mode = m; c_in_data = d; c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    v = c_out_valid; q = c_out_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (a_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready_held: got %b want 0", a_in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_par !== 4'h0 || a_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h par=%b ready=%b want 0/0/0/1",
               a_out_valid, a_out_data, a_out_par, a_in_ready);
    end
  endtask

  task automatic test_modes();
    logic v; logic [31:0] q; logic [3:0] p;
    logic [1:0]  m[4]  = '{MODE_FWD, MODE_INV, MODE_REV, MODE_BYPASS};
    logic [31:0] d[4]  = '{32'hAA55_8001, 32'h0FF0_0180, 32'h0000_000F, 32'hCAFE_F00D};
    logic [31:0] ex[4] = '{32'h0FF0_0180, 32'hAA55_8001, 32'h0000_00F0, 32'hCAFE_F00D};
    for (int i = 0; i < 4; i++) begin
      txn_a(m[i], d[i], v, q, p);
      vectors++;
      if (v !== 1'b1 || q !== ex[i]) begin
        miscompares++;
        $display("FAIL mode_%0d: valid=%b data=%h want valid=1 data=%h", m[i], v, q, ex[i]);
      end
    end
  endtask

  task automatic test_parity();
    logic v; logic [31:0] q; logic [3:0] p; logic [3:0] ep;
`ifdef MAP_PARITY_EN
    ep = 4'b0001;
`else
    ep = 4'b0000;
`endif
    txn_a(MODE_FWD, 32'h0000_0007, v, q, p);
    vectors++;
    if (q !== 32'h0000_00C8 || p !== ep) begin
      miscompares++;
      $display("FAIL parity_fwd: data=%h par=%b want data=000000c8 par=%b", q, p, ep);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sm[8] = '{MODE_FWD, MODE_INV, MODE_REV, MODE_BYPASS,
                           MODE_REV, MODE_FWD, MODE_INV, MODE_BYPASS};
    logic [31:0] sd[8] = '{32'hAA55_8001, 32'h0FF0_0180, 32'h0000_000F, 32'h1234_5678,
                           32'h0102_0408, 32'h0000_0007, 32'h0000_00C8, 32'hDEAD_BEEF};
    logic [31:0] sx[8] = '{32'h0FF0_0180, 32'hAA55_8001, 32'h0000_00F0, 32'h1234_5678,
                           32'h8040_2010, 32'h0000_00C8, 32'h0000_0007, 32'hDEAD_BEEF};
    int in_i = 0, out_i = 0;
    bit saw_low = 0, prev_stall = 0;
    logic [31:0] prev_data = '0;
    a_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 40 && out_i < 8; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 3 && cyc <= 5);
      if (in_i < 8) begin
        a_in_valid = 1'b1; a_in_data = sd[in_i]; a_in_mode = sm[in_i];
      end else a_in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_data !== prev_data) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h", a_out_valid, a_out_data, prev_data);
        end
      end
      if (!a_in_ready) saw_low = 1;
      if (a_out_valid && a_out_ready) begin
        vectors++;
        if (a_out_data !== sx[out_i]) begin
          miscompares++;
          $display("FAIL stream_beat%0d: data=%h want %h", out_i, a_out_data, sx[out_i]);
        end
        out_i++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
      if (a_in_valid && a_in_ready) in_i++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    vectors++;
    if (out_i != 8 || !saw_low) begin
      miscompares++;
      $display("FAIL stream_count: beats=%0d in_ready_fell=%0d want 8/1", out_i, saw_low);
    end
  endtask

  task automatic test_reset_mid();
    logic v; logic [31:0] q; logic [3:0] p;
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = MODE_BYPASS; a_in_data = 32'h1111_1111;
    @(negedge clk);
    a_in_data = 32'h2222_2222;
    @(negedge clk);
    a_in_valid = 1'b0;
    vectors++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_full_setup: valid=%b ready=%b want 1/0", a_out_valid, a_in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_par !== 4'h0 || a_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b data=%h par=%b ready=%b want 0/0/0/1",
               a_out_valid, a_out_data, a_out_par, a_in_ready);
    end
    txn_a(MODE_REV, 32'h0000_000F, v, q, p);
    vectors++;
    if (v !== 1'b1 || q !== 32'h0000_00F0) begin
      miscompares++;
      $display("FAIL post_reset_latency: valid=%b data=%h want 1/000000f0", v, q);
    end
  endtask

  task automatic test_sweep();
    logic v1, v2; logic [31:0] x, y, z; logic [1:0] cx, cy, cz;
    for (int n = 0; n < 1000; n++) begin
      x = $urandom;
      txn_b(MODE_FWD, x, v1, y);
      txn_b(MODE_INV, y, v2, z);
      vectors++;
      if (!(v1 && v2) || z !== x) begin
        miscompares++; $display("FAIL sweep_b_fwdinv: x=%h got %h", x, z);
      end
      txn_b(MODE_REV, x, v1, y);
      txn_b(MODE_REV, y, v2, z);
      vectors++;
      if (!(v1 && v2) || z !== x) begin
        miscompares++; $display("FAIL sweep_b_revrev: x=%h got %h", x, z);
      end
      cx = 2'($urandom_range(0, 3));
      txn_c(MODE_FWD, cx, v1, cy);
      vectors++;
      if (!v1 || cy !== {cx[0], cx[1]}) begin
        miscompares++; $display("FAIL sweep_c_fwd: x=%b got %b want %b", cx, cy, {cx[0], cx[1]});
      end
      txn_c(MODE_INV, cy, v2, cz);
      vectors++;
      if (!v2 || cz !== cx) begin
        miscompares++; $display("FAIL sweep_c_fwdinv: x=%b got %b", cx, cz);
      end
      txn_c(MODE_REV, cx, v1, cy);
      txn_c(MODE_REV, cy, v2, cz);
      vectors++;
      if (!(v1 && v2) || cz !== cx) begin
        miscompares++; $display("FAIL sweep_c_revrev: x=%b got %b", cx, cz);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_modes();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
